// File: rtl/gpu_cmd_pkg.sv
// Shared constants, arbiter state encoding and read-command decode for the GPU command port.
package gpu_cmd_pkg;

  localparam logic [15:0] CMD_NOP          = 16'd0;
  localparam logic [15:0] CMD_UPDATE_FRAME = 16'd1;
  localparam logic [6:0]  OP_READ_HDR      = 7'b0100100;
  localparam logic [6:0]  OP_WRITE_HDR     = 7'b1000100;

  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Header/register reads are the only commands that produce return data.
  function automatic logic is_read(input logic [15:0] cmd);
    return cmd[15:14] == 2'b01;
  endfunction

endpackage

// File: rtl/gpu_rd_tag_pipe.sv
// Delay line of {valid,id} tags that lines up each issued read with its returning data.
module gpu_rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IDW   = 1
) (
  input  logic           gpuClock,
  input  logic           reset,
  input  logic           pushValid,
  input  logic [IDW-1:0] pushId,
  output logic           popValid,
  output logic [IDW-1:0] popId
);

  logic [DEPTH-1:0] validPipe;
  logic [IDW-1:0]   idPipe [DEPTH];

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      validPipe <= '0;
      for (int i = 0; i < DEPTH; i++) idPipe[i] <= '0;
    end else begin
      validPipe[0] <= pushValid;
      idPipe[0]    <= pushId;
      for (int i = 1; i < DEPTH; i++) begin
        validPipe[i] <= validPipe[i-1];
        idPipe[i]    <= idPipe[i-1];
      end
    end
  end

  assign popValid = validPipe[DEPTH-1];
  assign popId    = idPipe[DEPTH-1];

endmodule

// File: rtl/gpu_cmd_arbiter.sv
// Round-robin arbiter for the shared GPU command port with beat locking and read-return routing.
// States: ARB | round-robin among all requesters ;  LOCKED | only the lock owner may issue, idle timer runs
module gpu_cmd_arbiter
  import gpu_cmd_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_TIMEOUT = 64,
  parameter int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   gpuClock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     lock,
  input  logic [16*NUM_REQ-1:0]  reqCmd,
  input  logic [16*NUM_REQ-1:0]  reqData,
  input  logic                   gpuBusyController,
  input  logic [15:0]            dataFromGpu,
  output logic [NUM_REQ-1:0]     ack,
  output logic [15:0]            gpuCommand,
  output logic [15:0]            gpuData,
  output logic [IDW-1:0]         grantId,
  output logic [NUM_REQ-1:0]     rdValid,
  output logic [15:0]            rdData,
  output logic                   lockTimeout
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [0:0]     state;
  logic [IDW-1:0] rrPtr;
  logic [IDW-1:0] owner;
  logic [TW-1:0]  lockTimer;

  logic [15:0]    cmdArr  [NUM_REQ];
  logic [15:0]    dataArr [NUM_REQ];
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic           accept;
  logic           tagValid;
  logic [IDW-1:0] tagId;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmdArr[i]  = reqCmd[16*i +: 16];
      dataArr[i] = reqData[16*i +: 16];
    end
  end

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    winner = owner;
    cand   = '0;
    found  = 1'b0;
    if (state == ARB) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        cand = IDW'((int'(rrPtr) + off) % NUM_REQ);
        if (!found && req[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end else begin
      found = req[owner];
    end
    accept = found && !gpuBusyController && reset;
    ack    = '0;
    if (accept) ack[winner] = 1'b1;
  end

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      state       <= ARB;
      rrPtr       <= IDW'(NUM_REQ - 1);
      owner       <= '0;
      lockTimer   <= '0;
      gpuCommand  <= CMD_NOP;
      gpuData     <= '0;
      grantId     <= '0;
      lockTimeout <= 1'b0;
    end else begin
      lockTimeout <= 1'b0;
      if (accept) begin
        gpuCommand <= cmdArr[winner];
        gpuData    <= dataArr[winner];
        grantId    <= winner;
      end else begin
        gpuCommand <= CMD_NOP;
        gpuData    <= '0;
      end

      case (state)
        ARB: begin
          if (accept) begin
            rrPtr <= winner;
            if (lock[winner]) begin
              state     <= LOCKED;
              owner     <= winner;
              lockTimer <= '0;
            end
          end
        end
        default: begin
          if (accept) begin
            lockTimer <= '0;
            if (!lock[owner]) state <= ARB;
          end else if (!gpuBusyController) begin
            // Owner idle: release once it has stalled for LOCK_TIMEOUT cycles.
            if (lockTimer >= TW'(LOCK_TIMEOUT - 1)) begin
              state       <= ARB;
              lockTimer   <= '0;
              lockTimeout <= 1'b1;
            end else begin
              lockTimer <= lockTimer + 1'b1;
            end
          end
        end
      endcase
    end
  end

  gpu_rd_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .IDW   (IDW)
  ) rdTagPipe (
    .gpuClock  (gpuClock),
    .reset     (reset),
    .pushValid (is_read(gpuCommand)),
    .pushId    (grantId),
    .popValid  (tagValid),
    .popId     (tagId)
  );

  always_ff @(posedge gpuClock or negedge reset) begin
    if (!reset) begin
      rdValid <= '0;
      rdData  <= '0;
    end else begin
      rdValid <= tagValid ? (NUM_REQ'(1) << tagId) : '0;
      if (tagValid) rdData <= dataFromGpu;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_arbiter.sv
// Directed scenarios plus random traffic checked cycle by cycle against a queue-based reference model.
module tb_gpu_cmd_arbiter;
  import gpu_cmd_pkg::*;

  localparam int N   = 2;
  localparam int RL  = 2;
  localparam int LT  = 4;
  localparam int IDW = 1;

  logic             gpuClock = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     lock = '0;
  logic [16*N-1:0]  reqCmd = '0;
  logic [16*N-1:0]  reqData = '0;
  logic             gpuBusyController = 1'b0;
  logic [15:0]      dataFromGpu = '0;
  logic [N-1:0]     ack;
  logic [15:0]      gpuCommand;
  logic [15:0]      gpuData;
  logic [IDW-1:0]   grantId;
  logic [N-1:0]     rdValid;
  logic [15:0]      rdData;
  logic             lockTimeout;

  int testCount = 0;
  int failCount = 0;
  string phase = "reset";

  always #5 gpuClock = ~gpuClock;

  gpu_cmd_arbiter #(
    .NUM_REQ      (N),
    .READ_LATENCY (RL),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .gpuClock          (gpuClock),
    .reset             (reset),
    .req               (req),
    .lock              (lock),
    .reqCmd            (reqCmd),
    .reqData           (reqData),
    .gpuBusyController (gpuBusyController),
    .dataFromGpu       (dataFromGpu),
    .ack               (ack),
    .gpuCommand        (gpuCommand),
    .gpuData           (gpuData),
    .grantId           (grantId),
    .rdValid           (rdValid),
    .rdData            (rdData),
    .lockTimeout       (lockTimeout)
  );

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, actual, expected);
    end
  endtask

  // Reference model: pointer/owner as plain ints, outstanding reads as a due-cycle queue.
  int          mPtr, mOwner, mIdle, cycle;
  int          dueQ[$];
  int          idQ[$];
  logic [15:0] expCmd, expData, expRdData;
  int          expGid;
  logic [N-1:0] expRdValid;
  logic        expTo;

  task automatic modelReset();
    mPtr = N - 1; mOwner = -1; mIdle = 0;
    expCmd = '0; expData = '0; expRdData = '0; expGid = 0;
    expRdValid = '0; expTo = 1'b0;
    dueQ.delete(); idQ.delete();
  endtask

  task automatic checkOutputs();
    checkEq("gpuCommand", 32'(gpuCommand), 32'(expCmd));
    checkEq("gpuData", 32'(gpuData), 32'(expData));
    checkEq("grantId", 32'(grantId), 32'(expGid));
    checkEq("rdValid", 32'(rdValid), 32'(expRdValid));
    checkEq("rdData", 32'(rdData), 32'(expRdData));
    checkEq("lockTimeout", 32'(lockTimeout), 32'(expTo));
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks ack mid-cycle and outputs after the edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic [15:0] c0, input logic [15:0] c1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic b, input logic [15:0] dfg);
    int win;
    logic [N-1:0] eAck;
    logic [15:0] wc;
    req = r; lock = l; reqCmd = {c1, c0}; reqData = {d1, d0};
    gpuBusyController = b; dataFromGpu = dfg;
    #2;
    win = -1;
    if (!b) begin
      if (mOwner < 0) begin
        for (int off = 1; off <= N; off++)
          if (win < 0 && r[(mPtr + off) % N]) win = (mPtr + off) % N;
      end else if (r[mOwner]) begin
        win = mOwner;
      end
    end
    eAck = '0;
    if (win >= 0) eAck[win] = 1'b1;
    checkEq("ack", 32'(ack), 32'(eAck));

    expRdValid = '0;
    if (dueQ.size() > 0 && dueQ[0] == cycle) begin
      expRdValid[idQ[0]] = 1'b1;
      expRdData = dfg;
      void'(dueQ.pop_front());
      void'(idQ.pop_front());
    end
    expTo = 1'b0;
    if (win >= 0) begin
      wc = (win == 1) ? c1 : c0;
      expCmd = wc;
      expData = (win == 1) ? d1 : d0;
      expGid = win;
      mPtr = win;
      if (mOwner < 0) begin
        if (l[win]) begin mOwner = win; mIdle = 0; end
      end else begin
        mIdle = 0;
        if (!l[win]) mOwner = -1;
      end
      if ((wc >> 14) == 16'd1) begin
        dueQ.push_back(cycle + 1 + RL);
        idQ.push_back(win);
      end
    end else begin
      expCmd = '0;
      expData = '0;
      if (mOwner >= 0 && !b) begin
        mIdle++;
        if (mIdle == LT) begin mOwner = -1; mIdle = 0; expTo = 1'b1; end
      end
    end
    @(posedge gpuClock);
    cycle++;
    #1;
    checkOutputs();
  endtask

  function automatic logic [15:0] randCmd();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return {2'b01, 14'($urandom)};
      2:       return {2'b10, 14'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    modelReset();
    cycle = 0;
    repeat (2) @(posedge gpuClock);
    #1;
    checkOutputs();
    checkEq("ack", 32'(ack), 32'd0);
    #2 reset = 1'b1;
    @(posedge gpuClock); #1;
    checkOutputs();

    phase = "rr";
    for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'hA0A0, 16'hB0B0, 1'b0, 16'h0);
    step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);

    phase = "lock";
    step(2'b01, 2'b00, 16'h1234, 16'h0, 16'h1, 16'h0, 1'b0, 16'h0);
    step(2'b11, 2'b10, 16'h3000, 16'h4823, 16'h0, 16'h11, 1'b0, 16'h0);
    step(2'b11, 2'b10, 16'h3000, 16'h4824, 16'h0, 16'h12, 1'b0, 16'h0);
    step(2'b11, 2'b00, 16'h3000, 16'h8823, 16'h0, 16'h13, 1'b0, 16'h0);
    step(2'b11, 2'b00, 16'h3000, 16'h9999, 16'h0, 16'h14, 1'b0, 16'h0);
    checkEq("ownerRelease", 32'(grantId), 32'd0);

    phase = "read";
    step(2'b10, 2'b00, 16'h0, 16'h4863, 16'h0, 16'h0, 1'b0, 16'h0);
    step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'hBEEF);
    checkEq("beefValid", 32'(rdValid), 32'h2);
    checkEq("beefData", 32'(rdData), 32'hBEEF);
    step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);

    phase = "busy";
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 16'h5555, 16'h0, 16'h5, 16'h0, 1'b1, 16'h0);
    step(2'b01, 2'b00, 16'h5555, 16'h0, 16'h5, 16'h0, 1'b0, 16'h0);

    phase = "timeout";
    step(2'b01, 2'b01, 16'h6001, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < LT; i++) step(2'b10, 2'b00, 16'h0, 16'h7001, 16'h0, 16'h0, 1'b0, 16'h0);
    checkEq("timeoutPulse", 32'(lockTimeout), 32'd1);
    step(2'b10, 2'b00, 16'h0, 16'h7001, 16'h0, 16'h0, 1'b0, 16'h0);

    phase = "random";
    for (int i = 0; i < 1500; i++)
      step(N'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 3)) : '0,
           randCmd(), randCmd(), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 6) == 0), 16'($urandom));

    phase = "midReset";
    step(2'b01, 2'b00, 16'h4001, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0);
    step(2'b10, 2'b00, 16'h0, 16'h4002, 16'h0, 16'h0, 1'b0, 16'h0);
    req = 2'b11; reqCmd = {16'h4004, 16'h4003};
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutputs();
    checkEq("ackInReset", 32'(ack), 32'd0);
    @(posedge gpuClock); @(posedge gpuClock);
    req = '0; lock = '0;
    #2 reset = 1'b1;
    @(posedge gpuClock); #1;
    checkOutputs();
    for (int i = 0; i < RL + 2; i++) step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'hDEAD);
    step(2'b10, 2'b00, 16'h0, 16'h2222, 16'h0, 16'h0, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
